// File: rtl/semaforo_monitor.sv
// Passive checker for the two one-hot lamp buses of the traffic-light controller.
// Each bus gets its own decode, dwell counter and sequence/timing tracker; irq merges both channels.

module semaforo_monitor_ch #(
    parameter int unsigned VERDE    = 10,
    parameter int unsigned AMARELO  = 3,
    parameter int unsigned VERMELHO = 8,
    parameter int unsigned TOL      = 1,
    parameter int unsigned CNT_W    = 9,
    parameter int unsigned CYC_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_err_i,
    input  logic [2:0]       lamp_i,
    output logic [1:0]       state_o,
    output logic             err_enc_o,
    output logic             err_seq_o,
    output logic             err_time_o,
    output logic [CYC_W-1:0] cycles_o,
    output logic             event_o
);

    typedef enum logic [1:0] {INIT, GREEN, YELLOW, RED} phase_e;

    localparam logic [CNT_W-1:0] DWELL_MAX = '1;

    logic [2:0]       code_q;
    logic [CNT_W-1:0] dwell_q;
    phase_e           phase_q;
    logic             armed_q;
    logic             err_enc_q, err_seq_q, err_time_q;
    logic [CYC_W-1:0] cycles_q;

    logic [1:0] nxt_col, cur_col;
    int         lo_lim, hi_lim;
    logic       tracking, change, legal;
    logic       enc_ev, seq_ev, time_ev;

    function automatic logic [1:0] decode(input logic [2:0] code);
        case (code)
            3'b100:  return 2'd0;
            3'b010:  return 2'd1;
            3'b001:  return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic phase_e to_phase(input logic [1:0] col);
        case (col)
            2'd0:    return GREEN;
            2'd1:    return YELLOW;
            2'd2:    return RED;
            default: return INIT;
        endcase
    endfunction

    assign state_o = decode(code_q);

    // Decisions use the incoming code against the registered one, so the exiting
    // phase's length is still in dwell_q at the edge that ends it.
    always_comb begin
        nxt_col = decode(lamp_i);
        cur_col = 2'd3;
        lo_lim  = 0;
        hi_lim  = 0;
        case (phase_q)
            GREEN: begin
                cur_col = 2'd0;
                lo_lim  = int'(VERDE) - int'(TOL);
                hi_lim  = int'(VERDE) + int'(TOL) + 1;
            end
            YELLOW: begin
                cur_col = 2'd1;
                lo_lim  = int'(AMARELO) - int'(TOL);
                hi_lim  = int'(AMARELO) + int'(TOL) + 1;
            end
            RED: begin
                cur_col = 2'd2;
                lo_lim  = int'(VERMELHO) - int'(TOL);
                hi_lim  = int'(VERMELHO) + int'(TOL) + 1;
            end
            default: ;
        endcase
        tracking = (phase_q != INIT);
        change   = tracking && (nxt_col != 2'd3) && (nxt_col != cur_col);
        legal    = ((phase_q == GREEN)  && (nxt_col == 2'd1)) ||
                   ((phase_q == YELLOW) && (nxt_col == 2'd2)) ||
                   ((phase_q == RED)    && (nxt_col == 2'd0));
        enc_ev   = en_i && (nxt_col == 2'd3);
        seq_ev   = en_i && change && !legal;
        time_ev  = en_i && tracking && armed_q &&
                   ((change && legal && (int'(dwell_q) < lo_lim)) ||
                    (int'(dwell_q) == hi_lim));
        event_o  = enc_ev || seq_ev || time_ev;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            code_q     <= '0;
            dwell_q    <= '0;
            phase_q    <= INIT;
            armed_q    <= 1'b0;
            err_enc_q  <= 1'b0;
            err_seq_q  <= 1'b0;
            err_time_q <= 1'b0;
            cycles_q   <= '0;
        end else begin
            code_q <= lamp_i;
            if (lamp_i != code_q) begin
                dwell_q <= CNT_W'(1);
            end else if (dwell_q != DWELL_MAX) begin
                dwell_q <= dwell_q + CNT_W'(1);
            end

            err_enc_q  <= enc_ev  || (err_enc_q  && !clr_err_i);
            err_seq_q  <= seq_ev  || (err_seq_q  && !clr_err_i);
            err_time_q <= time_ev || (err_time_q && !clr_err_i);

            if (!en_i) begin
                phase_q <= INIT;
                armed_q <= 1'b0;
            end else if (nxt_col == 2'd3) begin
                phase_q <= INIT;
                armed_q <= 1'b0;
            end else if (phase_q == INIT) begin
                phase_q <= to_phase(nxt_col);
                armed_q <= 1'b0;
            end else if (change) begin
                phase_q <= to_phase(nxt_col);
                armed_q <= legal;
                if (legal && (phase_q == RED)) begin
                    cycles_q <= cycles_q + CYC_W'(1);
                end
            end
        end
    end

    assign err_enc_o  = err_enc_q;
    assign err_seq_o  = err_seq_q;
    assign err_time_o = err_time_q;
    assign cycles_o   = cycles_q;

endmodule

module semaforo_monitor #(
    parameter int unsigned VERDE    = 10,
    parameter int unsigned AMARELO  = 3,
    parameter int unsigned VERMELHO = 8,
    parameter int unsigned TOL      = 1,
    parameter int unsigned CNT_W    = 9,
    parameter int unsigned CYC_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_err,
    input  logic [2:0]       A,
    input  logic [2:0]       B,
    output logic [1:0]       state_a,
    output logic [1:0]       state_b,
    output logic             err_enc_a,
    output logic             err_enc_b,
    output logic             err_seq_a,
    output logic             err_seq_b,
    output logic             err_time_a,
    output logic             err_time_b,
    output logic [CYC_W-1:0] cycles_a,
    output logic [CYC_W-1:0] cycles_b,
    output logic             irq
);

    logic ev_a, ev_b;
    logic irq_q;

    semaforo_monitor_ch #(
        .VERDE(VERDE), .AMARELO(AMARELO), .VERMELHO(VERMELHO),
        .TOL(TOL), .CNT_W(CNT_W), .CYC_W(CYC_W)
    ) u_ch_a (
        .clk_i      (clk),
        .rst_ni     (rst),
        .en_i       (en),
        .clr_err_i  (clr_err),
        .lamp_i     (A),
        .state_o    (state_a),
        .err_enc_o  (err_enc_a),
        .err_seq_o  (err_seq_a),
        .err_time_o (err_time_a),
        .cycles_o   (cycles_a),
        .event_o    (ev_a)
    );

    semaforo_monitor_ch #(
        .VERDE(VERDE), .AMARELO(AMARELO), .VERMELHO(VERMELHO),
        .TOL(TOL), .CNT_W(CNT_W), .CYC_W(CYC_W)
    ) u_ch_b (
        .clk_i      (clk),
        .rst_ni     (rst),
        .en_i       (en),
        .clr_err_i  (clr_err),
        .lamp_i     (B),
        .state_o    (state_b),
        .err_enc_o  (err_enc_b),
        .err_seq_o  (err_seq_b),
        .err_time_o (err_time_b),
        .cycles_o   (cycles_b),
        .event_o    (ev_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ev_a || ev_b;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Bench for semaforo_monitor: directed lamp sequences plus random traffic,
// every output compared each cycle against a phase-level reference model.

module tb_semaforo_monitor;

    localparam int VERDE    = 10;
    localparam int AMARELO  = 3;
    localparam int VERMELHO = 8;
    localparam int TOL      = 1;
    localparam int CNT_W    = 9;
    localparam int CYC_W    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, en, clr_err;
    logic [2:0]       A, B;
    logic [1:0]       state_a, state_b;
    logic             err_enc_a, err_enc_b, err_seq_a, err_seq_b, err_time_a, err_time_b;
    logic [CYC_W-1:0] cycles_a, cycles_b;
    logic             irq;

    semaforo_monitor #(
        .VERDE(VERDE), .AMARELO(AMARELO), .VERMELHO(VERMELHO),
        .TOL(TOL), .CNT_W(CNT_W), .CYC_W(CYC_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .A(A), .B(B),
        .state_a(state_a), .state_b(state_b),
        .err_enc_a(err_enc_a), .err_enc_b(err_enc_b),
        .err_seq_a(err_seq_a), .err_seq_b(err_seq_b),
        .err_time_a(err_time_a), .err_time_b(err_time_b),
        .cycles_a(cycles_a), .cycles_b(cycles_b), .irq(irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference model: a phase is a run of one colour; col = -1 means not tracking.
    int m_code[2], m_run[2], m_col[2], m_cyc[2];
    bit m_armed[2], m_enc[2], m_seq[2], m_time[2];
    bit m_irq;

    function automatic int plen(input int c);
        if (c == 0) return VERDE;
        if (c == 1) return AMARELO;
        return VERMELHO;
    endfunction

    function automatic int colour_of(input logic [2:0] x);
        if (x == 3'b100) return 0;
        if (x == 3'b010) return 1;
        if (x == 3'b001) return 2;
        return 3;
    endfunction

    function automatic logic [2:0] lamp_of(input int c);
        logic [2:0] v;
        v = 3'b100;
        return v >> c;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_code[c] = 0; m_run[c] = 0; m_col[c] = -1; m_cyc[c] = 0;
            m_armed[c] = 0; m_enc[c] = 0; m_seq[c] = 0; m_time[c] = 0;
        end
        m_irq = 0;
    endtask

    task automatic model_step(input logic [2:0] a, input logic [2:0] b, input bit en_v, input bit clr_v);
        bit any;
        any = 0;
        for (int c = 0; c < 2; c++) begin
            logic [2:0] x;
            int nc;
            bit e_enc, e_seq, e_time, legal;
            x = (c == 0) ? a : b;
            nc = colour_of(x);
            e_enc = 0; e_seq = 0; e_time = 0;
            if (en_v) begin
                if (m_col[c] >= 0 && m_armed[c] && m_run[c] == plen(m_col[c]) + TOL + 1) e_time = 1;
                if (nc == 3) begin
                    e_enc = 1; m_col[c] = -1; m_armed[c] = 0;
                end else if (m_col[c] < 0) begin
                    m_col[c] = nc; m_armed[c] = 0;
                end else if (nc != m_col[c]) begin
                    legal = (nc == (m_col[c] + 1) % 3);
                    if (!legal) e_seq = 1;
                    else begin
                        if (m_armed[c] && m_run[c] < plen(m_col[c]) - TOL) e_time = 1;
                        if (m_col[c] == 2) m_cyc[c] = (m_cyc[c] + 1) % (1 << CYC_W);
                    end
                    m_col[c] = nc; m_armed[c] = legal;
                end
            end else begin
                m_col[c] = -1; m_armed[c] = 0;
            end
            if (int'(x) != m_code[c]) m_run[c] = 1;
            else if (m_run[c] < (1 << CNT_W) - 1) m_run[c]++;
            m_code[c] = int'(x);
            m_enc[c]  = e_enc  || (m_enc[c]  && !clr_v);
            m_seq[c]  = e_seq  || (m_seq[c]  && !clr_v);
            m_time[c] = e_time || (m_time[c] && !clr_v);
            any = any || e_enc || e_seq || e_time;
        end
        m_irq = any;
    endtask

    task automatic compare_all();
        chk("state_a", state_a, colour_of(3'(m_code[0])));
        chk("state_b", state_b, colour_of(3'(m_code[1])));
        chk("err_enc_a", err_enc_a, m_enc[0]);
        chk("err_enc_b", err_enc_b, m_enc[1]);
        chk("err_seq_a", err_seq_a, m_seq[0]);
        chk("err_seq_b", err_seq_b, m_seq[1]);
        chk("err_time_a", err_time_a, m_time[0]);
        chk("err_time_b", err_time_b, m_time[1]);
        chk("cycles_a", cycles_a, m_cyc[0]);
        chk("cycles_b", cycles_b, m_cyc[1]);
        chk("irq", irq, m_irq);
    endtask

    // Traffic generator: mode 0 = exact legal timing, 1 = random, 2 = driven by hand.
    int g_col[2], g_rem[2], g_mode[2];
    logic [2:0] g_code[2];
    logic [2:0] bad_codes[5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    task automatic gen(input int c, output logic [2:0] code);
        int r, len;
        if (g_rem[c] > 1) begin
            g_rem[c]--;
        end else if (g_mode[c] == 0) begin
            g_col[c] = (g_col[c] + 1) % 3;
            g_rem[c] = plen(g_col[c]);
            g_code[c] = lamp_of(g_col[c]);
        end else begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                g_code[c] = bad_codes[$urandom_range(0, 4)];
                g_rem[c] = 1;
            end else begin
                if (r < 14) g_col[c] = $urandom_range(0, 2);
                else g_col[c] = (g_col[c] + 1) % 3;
                len = plen(g_col[c]) + int'($urandom_range(0, 4)) - 2;
                if ($urandom_range(0, 9) == 0) len += 4;
                if (len < 1) len = 1;
                g_rem[c] = len;
                g_code[c] = lamp_of(g_col[c]);
            end
        end
        code = g_code[c];
    endtask

    task automatic tick();
        logic [2:0] nx;
        @(posedge clk);
        if (!rst) model_reset();
        else model_step(A, B, en, clr_err);
        #1;
        compare_all();
        if (g_mode[0] != 2) begin gen(0, nx); A = nx; end
        if (g_mode[1] != 2) begin gen(1, nx); B = nx; end
    endtask

    task automatic hold_a(input logic [2:0] code, input int n);
        g_mode[0] = 2;
        A = code;
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; clr_err = 1'b0;
        g_mode[0] = 2; g_col[0] = 0; g_rem[0] = 1; g_code[0] = 3'b100;
        g_mode[1] = 0; g_col[1] = 0; g_rem[1] = VERDE; g_code[1] = 3'b100;
        A = 3'b100; B = 3'b100;
        model_reset();

        repeat (3) tick();
        chk("rst_state_a", state_a, 3);
        chk("rst_cycles_a", cycles_a, 0);
        @(negedge clk);
        rst = 1'b1;

        hold_a(3'b100, 10); hold_a(3'b010, 3); hold_a(3'b001, 8);
        hold_a(3'b100, 10); hold_a(3'b010, 3); hold_a(3'b001, 8);
        hold_a(3'b100, 10);
        chk("clean_cycles_a", cycles_a, 2);
        chk("clean_errs_a", {err_enc_a, err_seq_a, err_time_a}, 0);

        hold_a(3'b001, 1);
        chk("gr_seq_a", err_seq_a, 1);
        chk("gr_irq", irq, 1);
        chk("gr_cycles_a", cycles_a, 2);
        hold_a(3'b001, 11);
        chk("gr_red_unchecked", err_time_a, 0);
        hold_a(3'b100, 10);
        hold_a(3'b010, 6);
        chk("long_yellow", err_time_a, 1);
        hold_a(3'b001, 8);
        clr_err = 1'b1; hold_a(3'b100, 1); clr_err = 1'b0;
        hold_a(3'b100, 9);
        hold_a(3'b010, 1);
        hold_a(3'b001, 1);
        chk("short_yellow", err_time_a, 1);
        hold_a(3'b001, 7);

        hold_a(3'b100, 10);
        hold_a(3'b110, 1);
        chk("bad_state_a", state_a, 3);
        chk("bad_enc_a", err_enc_a, 1);
        hold_a(3'b010, 3); hold_a(3'b001, 8);
        chk("b_clean", {err_enc_b, err_seq_b, err_time_b}, 0);

        g_mode[1] = 2;
        g_col[1] = (g_col[1] + 2) % 3;
        B = lamp_of(g_col[1]);
        clr_err = 1'b1;
        tick();
        chk("set_wins_b", err_seq_b, 1);
        tick();
        chk("clr_b", err_seq_b, 0);
        clr_err = 1'b0;
        g_code[1] = B; g_rem[1] = plen(g_col[1]); g_mode[1] = 0;

        g_mode[0] = 1; g_mode[1] = 1;
        g_col[0] = 2; g_code[0] = 3'b001; g_rem[0] = 1;
        for (int i = 0; i < 3000; i++) begin
            if (en && $urandom_range(0, 199) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
            clr_err = ($urandom_range(0, 29) == 0);
            tick();
            if (i == 1500) begin
                #2 rst = 1'b0;
                #1 model_reset();
                compare_all();
                tick();
                @(negedge clk);
                rst = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/semaforo_monitor.md
Name: semaforo_monitor

Overview:
- Passive checker at the receiving end of the lamp buses that the traffic-light controller drives.
- Samples the two one-hot lamp buses A and B, decodes each to a colour, and tracks each with an independent sequence/timing FSM.
- Raises sticky error flags for bad encodings, illegal colour order and out-of-tolerance phase lengths. Counts completed light cycles.
- Sits beside the controller in simulation and in the top-level self-check.

Parameters:
- VERDE, 10, required green phase length in clk cycles
- AMARELO, 3, required yellow phase length in clk cycles
- VERMELHO, 8, required red phase length in clk cycles
- TOL, 1, allowed ± deviation in cycles for every phase
- CNT_W, 9, dwell counter width
- CYC_W, 8, cycle counter width

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- en  in  1  checking enable; when 0 both FSMs are forced to INIT
- clr_err  in  1  synchronous clear of all sticky error flags
- A  in  3  lamp bus A: 100 = green, 010 = yellow, 001 = red
- B  in  3  lamp bus B, same encoding as A
- state_a  out  2  decoded A: 0 = green, 1 = yellow, 2 = red, 3 = invalid
- state_b  out  2  decoded B, same encoding as state_a
- err_enc_a, err_enc_b  out  1 each  sticky: non-one-hot code seen
- err_seq_a, err_seq_b  out  1 each  sticky: illegal colour transition
- err_time_a, err_time_b  out  1 each  sticky: phase length out of tolerance
- cycles_a, cycles_b  out  CYC_W each  count of legal red→green transitions
- irq  out  1  one-cycle pulse on any new error event in either channel

Behaviour:
- Reset (rst=0, async): all outputs 0 except state_a and state_b, which are 3. FSMs go to INIT, dwell counters go to 0, input registers go to 000.
- Input path:
  - A and B are registered once.
  - The decoded state is combinational from the registered code, so state_x lags the lamp bus by 1 cycle.
  - Codes 000, 011, 101, 110 and 111 decode to 3.
- Dwell counter (per channel):
  - Loads 1 on the first cycle of a new registered code, otherwise increments.
  - Saturates at 2^CNT_W−1.
  - A phase of N cycles therefore has dwell=N at its exit edge.
- FSM states per channel: INIT, GREEN, YELLOW, RED.
  - INIT → colour state on the first valid code. No checks are made and armed is set to 0.
  - Legal transitions: GREEN→YELLOW→RED→GREEN.
  - Any other change between valid colours: set err_seq, move to the new colour, set armed=0.
  - Invalid code in any state: set err_enc, go to INIT, set armed=0.
- Armed flag:
  - Set to 1 on every legal transition.
  - A phase's length is checked only when the phase was entered with armed=1. The first phase after reset, en, or a resync is never checked.
- Timing check (armed phases only):
  - On exit via a legal transition with dwell < P−TOL: set err_time.
  - While in the phase, when dwell reaches P+TOL+1: set err_time once. There is no repeat during the same phase.
  - P is VERDE, AMARELO or VERMELHO according to the phase.
- cycles_x increments on each legal RED→GREEN transition and wraps modulo 2^CYC_W.
- Sticky flags:
  - Set by events and cleared by clr_err.
  - If a set and clr_err occur in the same cycle, set wins.
- irq is high for exactly 1 cycle after any cycle containing at least one error event. This holds even when the flag was already set.
- en=0: both FSMs are held in INIT with armed=0 and no error events or counting. Input registers and state_x keep tracking.
- Events on channels A and B are fully independent. Simultaneous events on both channels produce a single irq pulse.

Test Plan:
All scenarios use default parameters.
1. Hold rst=0 mid-phase, then release → all flags 0, cycles_a=cycles_b=0, state_a=state_b=3 until the first sampled code.
2. Drive A: G10, Y3, R8, G10, Y3, R8, G → no errors. cycles_a increments once at each R→G (1, then 2); state_a follows the bus with 1-cycle lag.
3. Armed A: G10 then directly R → err_seq_a=1, irq pulses 1 cycle, cycles_a unchanged. The following R phase is not timing-checked.
4. Armed A: yellow held 6 cycles → err_time_a sets when dwell=5, irq pulses once only. Yellow held 1 cycle → err_time_a sets at the Y→R exit.
5. A=110 for 1 cycle → state_a=3, err_enc_a=1, FSM resyncs on the next valid code. B traffic stays clean and err_*_b stay 0.
6. Assert clr_err in the same cycle as a new err_seq_b event → flag stays 1. clr_err alone on the next cycle → flag clears to 0.
